// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the borrow polarity agreed with the adder family.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } state_e;

    // bout = 1 means a borrow occurred; equals the inverted carry of A + ~B + ~bin.
    localparam bit BORROW_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor slice: d = a - b - bin, bout = borrow out of this bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B - bin over WIDTH cycles, LSB first, with
// valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [1:0]       state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Handshake rule: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and ready is a pure state decode.

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               fs_d;
    logic               fs_bout;
    logic               last_bit;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit = (count_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                // Operands are only sampled here, so X outside an accept never reaches state.
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = bin;
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = {fs_d, diff_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                count_d  = count_q + CNT_W'(1);
                if (last_bit) begin
                    bout_d  = fs_bout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            count_q  <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): arithmetic model, per-cycle
// result checker with expected queue, backpressure and mid-operation reset.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic [1:0]   state_o;

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .state_o   (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: unsigned subtraction; bout is the plain "A < B + bin" comparison.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int r;
        logic [W-1:0] d;
        logic bo;
        r  = int'(a) - int'(b) - int'(bi);
        d  = W'((r + (1 << W)) % (1 << W));
        bo = (int'(a) < int'(b) + int'(bi));
        return {bo, d};
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_diff", int'(diff), 0);
            chk("rst_bout", int'(bout), 0);
        end else if (out_valid) begin
            chk("done_in_ready", int'(in_ready), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("diff", int'(diff), int'(exp_q[0][W-1:0]));
                chk("bout", int'(bout), int'(exp_q[0][W]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input int stall, input bit use_lit,
                          input logic [W-1:0] lit_d, input logic lit_b);
        int n;
        logic [W:0] e;
        e = model(a, b, bi);
        A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        A = W'($urandom_range(0, 15)); B = W'($urandom_range(0, 15)); bin = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, W);
        if (!out_valid) return;
        if (use_lit) begin
            chk("lit_diff", int'(diff), int'(lit_d));
            chk("lit_bout", int'(bout), int'(lit_b));
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            A = W'($urandom_range(0, 15)); B = W'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_diff", int'(diff), int'(e[W-1:0]));
            chk("stall_bout", int'(bout), int'(e[W]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_diff_held", int'(diff), int'(e[W-1:0]));
        chk("post_bout_held", int'(bout), int'(e[W]));
        chk("queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra, rb;
        logic rbi;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("reset_state", int'(state_o), 0);
        chk("reset_in_ready", int'(in_ready), 1);

        run_op(4'b0000, 4'b0000, 1'b0, 0, 1'b1, 4'b0000, 1'b0);
        run_op(4'b0000, 4'b0000, 1'b1, 0, 1'b1, 4'b1111, 1'b1);
        run_op(4'b1111, 4'b1111, 1'b0, 0, 1'b1, 4'b0000, 1'b0);
        run_op(4'b1111, 4'b1111, 1'b1, 0, 1'b1, 4'b1111, 1'b1);
        run_op(4'b0011, 4'b0101, 1'b0, 0, 1'b1, 4'b1110, 1'b1);
        run_op(4'b1000, 4'b0001, 1'b1, 0, 1'b1, 4'b0110, 1'b0);
        run_op(4'b0011, 4'b0101, 1'b0, 5, 1'b1, 4'b1110, 1'b1);

        for (int k = 0; k < 10; k++) begin
            ra  = W'($urandom_range(0, 15));
            rb  = W'($urandom_range(0, 15));
            rbi = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbi, int'($urandom_range(0, 2)), 1'b0, '0, 1'b0);
        end

        // Reset pulsed during the second SHIFT cycle.
        A = 4'b1010; B = 4'b0011; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(4'b1010, 4'b0011, 1'b0));
        #1 in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_bout", int'(bout), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'b0110, 4'b1001, 1'b1, 1, 1'b1, 4'b1100, 1'b1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
